// File: rtl/eth_led_pkg.sv
// Shared definitions for the Ethernet LED controller: FSM state encoding and
// led_status bit positions.
package eth_led_pkg;

    typedef enum logic [1:0] {
        DOWN      = 2'd0,
        IDLE      = 2'd1,
        BLINK_ON  = 2'd2,
        BLINK_OFF = 2'd3
    } led_state_e;

    localparam int LED_LINK  = 0;
    localparam int LED_SPEED = 1;
    localparam int LED_ACT   = 2;

endpackage

// File: rtl/eth_led_if.sv
// PHY-side inputs and LED outputs of the controller bundled as one interface.
// The lamp_test signal exists only when ETH_LED_LAMPTEST_EN is defined.
interface eth_led_if;

    logic       phy_link;
    logic       phy_speed100;
    logic       phy_act;
`ifdef ETH_LED_LAMPTEST_EN
    logic       lamp_test;
`endif
    logic [2:0] led_status;
    logic       link_up;
    logic       act_pulse;

`ifdef ETH_LED_LAMPTEST_EN
    modport master (output phy_link, phy_speed100, phy_act, lamp_test,
                    input  led_status, link_up, act_pulse);
    modport slave  (input  phy_link, phy_speed100, phy_act, lamp_test,
                    output led_status, link_up, act_pulse);
`else
    modport master (output phy_link, phy_speed100, phy_act,
                    input  led_status, link_up, act_pulse);
    modport slave  (input  phy_link, phy_speed100, phy_act,
                    output led_status, link_up, act_pulse);
`endif

endinterface

// File: rtl/eth_led_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer: the output
// follows the input only after DEB_CYCLES consecutive mismatching cycles.
module eth_led_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized value agrees with the output restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/eth_led_controller.sv
// Ethernet link/speed/activity LED controller with debounced link and speed
// and a pending-driven blink FSM. Optional lamp test: ETH_LED_LAMPTEST_EN.
module eth_led_controller
    import eth_led_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned BLINK_HALF = 1024
) (
    input  logic      clk,
    input  logic      rst,
    eth_led_if.slave  bus
);

    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    logic          link_deb, spd_deb, spd_eff;
    logic          act_s1_q, act_s2_q, act_prev_q;
    logic          act_edge, lamp, blink_done, enter_on;
    led_state_e    state_q, state_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          pending_q, pending_d;
    logic [2:0]    led_q, led_d;
    logic          link_up_q, link_up_d;
    logic          act_pulse_q, act_pulse_d;

    eth_led_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_link_deb (
        .clk(clk), .rst(rst), .raw_i(bus.phy_link), .stable_o(link_deb)
    );

    eth_led_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_speed_deb (
        .clk(clk), .rst(rst), .raw_i(bus.phy_speed100), .stable_o(spd_deb)
    );

`ifdef ETH_LED_LAMPTEST_EN
    assign lamp = bus.lamp_test;
`else
    assign lamp = 1'b0;
`endif

    assign spd_eff    = spd_deb & link_deb;
    assign act_edge   = act_s2_q & ~act_prev_q & link_up_q;
    assign blink_done = (blink_cnt_q == BW'(BLINK_HALF - 1));
    assign enter_on   = (state_d == BLINK_ON) && (state_q != BLINK_ON);

    // A debounced link loss overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (!link_deb) begin
            state_d = DOWN;
        end else begin
            case (state_q)
                DOWN:      state_d = IDLE;
                IDLE:      if (pending_q) state_d = BLINK_ON;
                BLINK_ON:  if (blink_done) state_d = BLINK_OFF;
                BLINK_OFF: if (blink_done) state_d = pending_q ? BLINK_ON : IDLE;
                default:   state_d = DOWN;
            endcase
        end
    end

    // Pending: a new edge beats the clear on BLINK_ON entry; going DOWN beats both.
    always_comb begin
        blink_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == BLINK_ON) || (state_q == BLINK_OFF))) begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
        pending_d = pending_q;
        if (enter_on) pending_d = 1'b0;
        if (act_edge) pending_d = 1'b1;
        if (state_d == DOWN) pending_d = 1'b0;
    end

    always_comb begin
        led_d            = 3'b000;
        led_d[LED_LINK]  = (state_q != DOWN);
        led_d[LED_SPEED] = spd_eff;
        led_d[LED_ACT]   = (state_q == BLINK_ON);
        if (lamp) led_d = 3'b111;
        link_up_d   = (state_q != DOWN);
        act_pulse_d = act_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_s1_q    <= 1'b0;
            act_s2_q    <= 1'b0;
            act_prev_q  <= 1'b0;
            state_q     <= DOWN;
            blink_cnt_q <= '0;
            pending_q   <= 1'b0;
            led_q       <= 3'b000;
            link_up_q   <= 1'b0;
            act_pulse_q <= 1'b0;
        end else begin
            act_s1_q    <= bus.phy_act;
            act_s2_q    <= act_s1_q;
            act_prev_q  <= act_s2_q;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            pending_q   <= pending_d;
            led_q       <= led_d;
            link_up_q   <= link_up_d;
            act_pulse_q <= act_pulse_d;
        end
    end

    assign bus.led_status = led_q;
    assign bus.link_up    = link_up_q;
    assign bus.act_pulse  = act_pulse_q;

endmodule

// File: tb/tb_eth_led_controller.sv
// Directed bench for eth_led_controller with DEB_CYCLES=4, BLINK_HALF=8.
// Lamp-test scenario is compiled in only with ETH_LED_LAMPTEST_EN.
module tb_eth_led_controller;
    import eth_led_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    eth_led_if bus();

    eth_led_controller #(.DEB_CYCLES(4), .BLINK_HALF(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on falling edges, away from the active edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.phy_link = 1'b0;
        bus.phy_speed100 = 1'b0;
        bus.phy_act = 1'b0;
`ifdef ETH_LED_LAMPTEST_EN
        bus.lamp_test = 1'b0;
`endif
        tick(2);
        rst = 1'b0;
    endtask

    task automatic bring_up();
        do_reset();
        bus.phy_link = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        bus.phy_link = 1'b1;
        bus.phy_act = 1'b1;
        tick(3);
        do_reset();
        checks++;
        if (bus.led_status !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_led: got %b want 000", bus.led_status);
        end
        checks++;
        if (bus.link_up !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_link_up: got %b want 0", bus.link_up);
        end
        checks++;
        if (bus.act_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_act_pulse: got %b want 0", bus.act_pulse);
        end
        checks++;
        if (dut.state_q !== DOWN) begin
            failures++;
            $display("[TB] FAIL reset_state: got %0d want %0d", dut.state_q, DOWN);
        end
    endtask

    task automatic test_link_debounce();
        int seen;
        do_reset();
        bus.phy_link = 1'b1;
        tick(7);
        checks++;
        if ({bus.link_up, bus.led_status[0]} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL link_early: got %b want 00", {bus.link_up, bus.led_status[0]});
        end
        tick(1);
        checks++;
        if ({bus.link_up, bus.led_status[0]} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL link_latency7: got %b want 11", {bus.link_up, bus.led_status[0]});
        end
        do_reset();
        bus.phy_link = 1'b1;
        tick(3);
        bus.phy_link = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (bus.link_up || bus.led_status[0]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL link_glitch: up for %0d cycles want 0", seen);
        end
    endtask

    task automatic test_single_activity();
        int pulses, pulse_at, first_on, on_cnt;
        bring_up();
        pulses = 0; pulse_at = -1; first_on = -1; on_cnt = 0;
        bus.phy_act = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (k == 1) bus.phy_act = 1'b0;
            if (bus.act_pulse) begin pulses++; pulse_at = k; end
            if (bus.led_status[2]) begin
                on_cnt++;
                if (first_on < 0) first_on = k;
            end
        end
        checks++;
        if (pulses !== 1 || pulse_at !== 3) begin
            failures++;
            $display("[TB] FAIL single_pulse: got %0d pulses at %0d want 1 at 3", pulses, pulse_at);
        end
        checks++;
        if (first_on !== 5) begin
            failures++;
            $display("[TB] FAIL single_on_start: got %0d want 5", first_on);
        end
        checks++;
        if (on_cnt !== 8) begin
            failures++;
            $display("[TB] FAIL single_on_len: got %0d want 8", on_cnt);
        end
        checks++;
        if (dut.state_q !== IDLE || bus.led_status !== 3'b001) begin
            failures++;
            $display("[TB] FAIL single_end: state %0d led %b want %0d 001", dut.state_q, bus.led_status, IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, periods;
        logic prev;
        bring_up();
        pulses = 0; periods = 0; prev = 1'b0;
        bus.phy_act = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            bus.phy_act = (k <= 8) && (k % 2 == 0);
            if (bus.act_pulse) pulses++;
            if (bus.led_status[2] && !prev) periods++;
            prev = bus.led_status[2];
        end
        checks++;
        if (pulses !== 5) begin
            failures++;
            $display("[TB] FAIL multi_pulses: got %0d want 5", pulses);
        end
        checks++;
        if (periods !== 2) begin
            failures++;
            $display("[TB] FAIL multi_periods: got %0d want 2", periods);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("[TB] FAIL multi_end_state: got %0d want %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_link_drop();
        logic led2_at5, led0_at8;
        int ignored;
        bring_up();
        led2_at5 = 1'b0; led0_at8 = 1'b0;
        bus.phy_act = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            if (k == 1) begin
                bus.phy_act = 1'b0;
                bus.phy_link = 1'b0;
            end
            if (k == 5) led2_at5 = bus.led_status[2];
            if (k == 8) led0_at8 = bus.led_status[0];
        end
        checks++;
        if (led2_at5 !== 1'b1 || led0_at8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_before: led2 %b led0 %b want 1 1", led2_at5, led0_at8);
        end
        checks++;
        if (bus.led_status !== 3'b000 || bus.link_up !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_leds: led %b up %b want 000 0", bus.led_status, bus.link_up);
        end
        checks++;
        if (dut.state_q !== DOWN) begin
            failures++;
            $display("[TB] FAIL drop_state: got %0d want %0d", dut.state_q, DOWN);
        end
        ignored = 0;
        for (int k = 0; k < 20; k++) begin
            bus.phy_act = (k % 4 == 0);
            tick(1);
            if (bus.act_pulse || bus.led_status != 3'b000) ignored++;
        end
        bus.phy_act = 1'b0;
        checks++;
        if (ignored !== 0) begin
            failures++;
            $display("[TB] FAIL drop_act_ignored: active %0d cycles want 0", ignored);
        end
    endtask

    task automatic test_speed();
        do_reset();
        bus.phy_speed100 = 1'b1;
        tick(12);
        checks++;
        if (bus.led_status[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL speed_link_down: got %b want 0", bus.led_status[1]);
        end
        bus.phy_link = 1'b1;
        tick(8);
        checks++;
        if (bus.led_status[1:0] !== 2'b11) begin
            failures++;
            $display("[TB] FAIL speed_link_up: got %b want 11", bus.led_status[1:0]);
        end
    endtask

    task automatic test_reset_mid_blink();
        bring_up();
        bus.phy_act = 1'b1;
        tick(1);
        bus.phy_act = 1'b0;
        tick(5);
        checks++;
        if (bus.led_status[2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_in_blink: got %b want 1", bus.led_status[2]);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({bus.led_status, bus.link_up, bus.act_pulse} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs: got %b want 00000", {bus.led_status, bus.link_up, bus.act_pulse});
        end
        checks++;
        if (dut.state_q !== DOWN) begin
            failures++;
            $display("[TB] FAIL rst_mid_state: got %0d want %0d", dut.state_q, DOWN);
        end
        rst = 1'b0;
    endtask

`ifdef ETH_LED_LAMPTEST_EN
    task automatic test_lamp();
        bring_up();
        bus.lamp_test = 1'b1;
        tick(1);
        checks++;
        if (bus.led_status !== 3'b111 || dut.state_q !== IDLE || bus.link_up !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lamp_on: led %b state %0d want 111 %0d", bus.led_status, dut.state_q, IDLE);
        end
        bus.lamp_test = 1'b0;
        tick(1);
        checks++;
        if (bus.led_status !== 3'b001) begin
            failures++;
            $display("[TB] FAIL lamp_release: got %b want 001", bus.led_status);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_link_debounce();
        test_single_activity();
        test_back_to_back();
        test_link_drop();
        test_speed();
        test_reset_mid_blink();
`ifdef ETH_LED_LAMPTEST_EN
        test_lamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
